// File: rtl/instr_fetch_spi.sv
// Instruction-fetch responder backed by an external SPI NOR flash (READ 0x03, mode 0, sck = clk/2).
// A one-entry address tag returns a repeated fetch of the same word without touching the flash.
module instr_fetch_spi #(
  parameter int          ADDR_W     = 8,
  parameter logic [23:0] FLASH_BASE = 24'h000000,
  parameter bit          CACHE_EN   = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              instr_req_i,
  input  logic [ADDR_W-1:0] instr_addr_i,
  output logic [31:0]       instr_o,
  output logic              instr_valid_o,
  output logic              busy_o,
  output logic              spi_cs_n_o,
  output logic              spi_sck_o,
  output logic              spi_mosi_o,
  input  logic              spi_miso_i
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_t;

  state_t              state_q, state_d;
  logic [7:0]          ph_q, ph_d;
  logic [31:0]         tx_q, tx_d;
  logic [31:0]         rx_q, rx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   tag_q, tag_d;
  logic                tag_vld_q, tag_vld_d;
  logic [31:0]         instr_q, instr_d;
  logic                cs_n_q, cs_n_d;
  logic                sck_q, sck_d;
  logic [23:0]         byte_addr;
  logic                hit;
  logic                active;

  function automatic logic [31:0] le_word(input logic [31:0] s);
    return {s[7:0], s[15:8], s[23:16], s[31:24]};
  endfunction

  assign byte_addr = FLASH_BASE + 24'({instr_addr_i, 2'b00});
  assign hit       = instr_req_i && CACHE_EN && tag_vld_q && (instr_addr_i == tag_q);
  assign active    = (state_q == CMD) || (state_q == ADDR) || (state_q == DATA);

  // ph_q 0 is the CS setup cycle; ph_q 1..128 are the two half-cycles of each of the 64 bits.
  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    addr_d    = addr_q;
    tag_d     = tag_q;
    tag_vld_d = tag_vld_q;
    instr_d   = instr_q;
    cs_n_d    = cs_n_q;
    sck_d     = 1'b0;
    if (active) begin
      ph_d  = ph_q + 8'd1;
      sck_d = ph_q[0];
      if (ph_q[0] && (ph_q >= 8'd65))
        rx_d = {rx_q[30:0], spi_miso_i};
      if (!ph_q[0] && (ph_q != 8'd0))
        tx_d = {tx_q[30:0], 1'b0};
    end
    case (state_q)
      IDLE: begin
        if (hit) begin
          state_d = DONE;
        end else if (instr_req_i) begin
          state_d = CMD;
          addr_d  = instr_addr_i;
          tx_d    = {8'h03, byte_addr};
          ph_d    = 8'd0;
          cs_n_d  = 1'b0;
        end
      end
      CMD:  if (ph_q == 8'd16) state_d = ADDR;
      ADDR: if (ph_q == 8'd64) state_d = DATA;
      DATA: begin
        if (ph_q == 8'd128) begin
          state_d   = DONE;
          cs_n_d    = 1'b1;
          instr_d   = le_word(rx_q);
          tag_d     = addr_q;
          tag_vld_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      ph_q      <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      addr_q    <= '0;
      tag_q     <= '0;
      tag_vld_q <= 1'b0;
      instr_q   <= 32'h0000_0013;
      cs_n_q    <= 1'b1;
      sck_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      addr_q    <= addr_d;
      tag_q     <= tag_d;
      tag_vld_q <= tag_vld_d;
      instr_q   <= instr_d;
      cs_n_q    <= cs_n_d;
      sck_q     <= sck_d;
    end
  end

  assign instr_o       = instr_q;
  assign instr_valid_o = (state_q == DONE);
  assign busy_o        = active;
  assign spi_cs_n_o    = cs_n_q;
  assign spi_sck_o     = sck_q;
  assign spi_mosi_o    = tx_q[31];

endmodule
